kogge_stone_adder: RTL and testbench

- N-bit parallel-prefix (Kogge-Stone) adder producing the (N+1)-bit result A + B + Cin.
- One registered output stage with a valid flag, for use as a single-cycle arithmetic datapath element.
- Carries must come from a log2(N)-level Kogge-Stone prefix network. A behavioural "+" or a ripple-carry chain is not acceptable.

---
 rtl/kogge_stone_adder.sv | 83 ++++++++
 tb/tb_kogge_stone_adder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/kogge_stone_adder.sv
// N-bit Kogge-Stone parallel-prefix adder with a single registered output stage.
// Optional signed-overflow output `ovf` is enabled by defining KOGGE_STONE_OVF_EN.
module kogge_stone_adder #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         out_valid,
`ifdef KOGGE_STONE_OVF_EN
  output logic         ovf,
`endif
  output logic [N:0]   Sum
);

  localparam int unsigned L = $clog2(N);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] g_lvl;
  logic [N-1:0] p_lvl;
  logic [N-1:0] g_nxt;
  logic [N-1:0] p_nxt;
  logic [N-1:0] c;
  logic [N:0]   sum_next;

  always_comb begin
    g    = A & B;
    p    = A ^ B;
    g[0] = (A[0] & B[0]) | ((A[0] ^ B[0]) & Cin);
  end

  // Each pass is one prefix level; the nxt copies keep every level reading only the previous one.
  always_comb begin
    g_lvl = g;
    p_lvl = p;
    g_nxt = '0;
    p_nxt = '0;
    for (int unsigned k = 0; k < L; k++) begin
      g_nxt = g_lvl;
      p_nxt = p_lvl;
      for (int unsigned i = 0; i < N; i++) begin
        if (i >= (32'd1 << k)) begin
          g_nxt[i] = g_lvl[i] | (p_lvl[i] & g_lvl[i - (32'd1 << k)]);
          p_nxt[i] = p_lvl[i] & p_lvl[i - (32'd1 << k)];
        end
      end
      g_lvl = g_nxt;
      p_lvl = p_nxt;
    end
  end

  always_comb begin
    c        = {g_lvl[N-2:0], Cin};
    sum_next = {g_lvl[N-1], p ^ c};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum <= sum_next;
      end
    end
  end

`ifdef KOGGE_STONE_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[N-1] ^ g_lvl[N-1];
    end
  end
`endif

endmodule

// File: tb/tb_kogge_stone_adder.sv
// Self-checking bench for kogge_stone_adder (N=16): directed boundary cases plus random
// operands checked against an arithmetic reference model; honours KOGGE_STONE_OVF_EN.
module tb_kogge_stone_adder;

  localparam int unsigned N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic [N:0]   Sum;
`ifdef KOGGE_STONE_OVF_EN
  logic         ovf;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [N:0] exp_sum   = '0;
  logic       exp_valid = 1'b0;
  logic       exp_ovf   = 1'b0;

  kogge_stone_adder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
`ifdef KOGGE_STONE_OVF_EN
    .ovf       (ovf),
`endif
    .Sum       (Sum)
  );

  always #5 clk = ~clk;

  initial begin
    #10ms;
    $display("FAIL timeout: simulation did not finish (observed running, expected done)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, advance the model and compare all outputs after the edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
    int sgn;
    rst_n    = r;
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = ci;
    @(posedge clk);
    #1;
    if (!r) begin
      exp_sum   = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        exp_sum = (N+1)'(a) + (N+1)'(b) + (N+1)'(ci);
        sgn     = int'($signed(a)) + int'($signed(b)) + int'(ci);
        exp_ovf = (sgn > 32767) || (sgn < -32768);
      end
    end
    chk({tag, ".sum"}, 32'(Sum), 32'(exp_sum));
    chk({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
`ifdef KOGGE_STONE_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;

    step("rst0", 1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    step("rst1", 1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    chk("rst_const", 32'(Sum), 32'h0);

    step("first", 1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    chk("first_const", 32'(Sum), 32'h10000);

    step("ripple", 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    chk("ripple_const", 32'(Sum), 32'h10000);
`ifdef KOGGE_STONE_OVF_EN
    chk("ripple_ovf_const", 32'(ovf), 32'h0);
`endif
    step("max", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("max_const", 32'(Sum), 32'h1FFFF);
    step("zero", 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0);
    chk("zero_const", 32'(Sum), 32'h0);

    step("povf", 1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    chk("povf_const", 32'(Sum), 32'h08000);
`ifdef KOGGE_STONE_OVF_EN
    chk("povf_ovf_const", 32'(ovf), 32'h1);
`endif
    step("novf", 1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0);
    chk("novf_const", 32'(Sum), 32'h10000);
`ifdef KOGGE_STONE_OVF_EN
    chk("novf_ovf_const", 32'(ovf), 32'h1);
`endif

    step("b2b0", 1'b1, 1'b1, 16'h1234, 16'h4321, 1'b0);
    chk("b2b0_const", 32'(Sum), 32'h05555);
    step("b2b1", 1'b1, 1'b1, 16'h00FF, 16'h0001, 1'b1);
    chk("b2b1_const", 32'(Sum), 32'h00101);
    step("hold0", 1'b1, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
    step("hold1", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("hold_const", 32'(Sum), 32'h00101);

    step("pre_rst", 1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b1);
    step("mid_rst", 1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b1);
    chk("mid_rst_valid_const", 32'(out_valid), 32'h0);
    step("post_rst", 1'b1, 1'b1, 16'h5555, 16'hAAAA, 1'b1);

    for (int unsigned t = 0; t < 3000; t++) begin
      step("rand", 1'b1, ($urandom_range(0, 7) != 0),
           N'($urandom), N'($urandom), 1'($urandom));
    end
    for (int unsigned t = 0; t < 200; t++) begin
      step("rand_edge", 1'b1, 1'b1,
           ($urandom_range(0, 1) != 0) ? 16'hFFFF : N'($urandom),
           ($urandom_range(0, 1) != 0) ? 16'h0000 : N'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
